prn_release_buffer: RTL and testbench
=====================================

// Module: prn_release_buffer
// PURPOSE
//  Retire-side producer for the physical-register free lists. Collects the stale (told) PRNs
//  freed by up to `N retiring instructions per cycle, compacts them into an in-order FIFO, and
//  drains them as FREE_LIST_PACKET pushes without exceeding the free list's remaining space.
//  Sits between ROB retire and the push_packet ports of rat_free_list / rrat_free_list.
// PARAMETERS
//  DEPTH     16                      FIFO entries; must be >= `N; any value, not only powers of 2
//  FL_SIZE   `PHYS_REG_SZ_R10K        capacity of the downstream free list
// PORTS
//  clock          in   1                         system clock, rising edge
//  reset          in   1                         asynchronous, active-low; clears all state
//  retire_packet  in   FREE_LIST_PACKET[`N]      told PRNs from retire; valid bits may be sparse
//  fl_counter     in   `FREE_LIST_CTR_WIDTH      downstream free list occupancy (counter_out)
//  push_packet    out  FREE_LIST_PACKET[`N]      pushes to free list, lanes 0..k-1 valid, rest 0
//  retire_ready   out  1                         1 when >= `N free FIFO entries
//  count          out  $clog2(DEPTH+1)           current FIFO occupancy
//  overflow       out  1                         sticky: a valid retire PRN was dropped
// BEHAVIOUR
//  - One clock. reset low (async assert, sync release): head=tail=count=0, overflow=0,
//    push_packet all {valid=0, prn=0}, retire_ready=1. Reset mid-operation discards all entries.
//  - Accept: valid retire lanes written in ascending lane order at tail; invalid lanes skipped
//    (lanes {0,2} valid -> two consecutive entries, lane-0 PRN first). tail wraps DEPTH-1 -> 0.
//  - Capacity: accepted = min(#valid, DEPTH - count) using count before this edge's drain; excess
//    lanes (highest lane first) dropped and overflow set until reset. Retire must honour
//    retire_ready; overflow is an error flag, never a silent normal path.
//  - Drain: k = min(count, `N, FL_SIZE - fl_counter), computed combinationally from current
//    state; push_packet[i] = {1, fifo[head+i mod DEPTH]} for i<k, else {0,0}. At the edge head
//    advances k (mod DEPTH). fl_counter >= FL_SIZE -> k=0.
//  - Latency: PRN accepted at edge t appears on push_packet in cycle t+1 at the earliest; no
//    same-cycle bypass from retire_packet to push_packet.
//  - Simultaneous accept and drain: next count = count + accepted - k; a full FIFO is not
//    freed for same-cycle accept by that cycle's drain (conservative).
//  - retire_ready, count are registered-state functions (no combinational path from inputs).
//  - Order preserved end to end; PRNs not checked for duplicates or value range.
//  - Squash has no effect: retired frees are architectural and always drained.
// TESTING
//  - Reset low mid-stream with count=5 -> cycle after: count=0, push_packet all invalid,
//    overflow=0, retire_ready=1.
//  - `N=2: retire lanes {0:PRN 40 invalid, 1:PRN 41 valid} then {43,44}, fl_counter=0 ->
//    push_packet {41} next cycle, then {43,44}; order kept.
//  - Fill to DEPTH with fl_counter=FL_SIZE -> no pushes, retire_ready=0 at count>DEPTH-`N;
//    then one valid lane retired at count=DEPTH -> dropped, overflow=1 sticky.
//  - fl_counter=FL_SIZE-1, count=4 -> exactly 1 push per cycle; head advances 1.
//  - Wrap: DEPTH=16, head=tail=15, accept 2, drain 2 -> entries from slots 15,0; head=tail=1.
//  - Steady state retire 2/cycle, drain 2/cycle -> count constant, no overflow over 100 cycles.

Source files
------------

// File: rtl/prn_release_buffer.sv
// Retire-side release buffer: compacts stale PRNs from up to N retiring lanes into an
// in-order FIFO and drains them as free-list pushes bounded by the free list's spare room.
package prn_release_pkg;
    localparam int N           = 2;
    localparam int PRN_W       = 6;
    localparam int PHYS_REG_SZ = 64;
    localparam int FL_CTR_W    = $clog2(PHYS_REG_SZ + 1);

    typedef struct packed {
        logic             valid;
        logic [PRN_W-1:0] prn;
    } free_list_packet_t;
endpackage

module prn_release_buffer
    import prn_release_pkg::*;
#(
    parameter int DEPTH   = 16,
    parameter int FL_SIZE = PHYS_REG_SZ
) (
    input  logic                         clock,
    input  logic                         reset,
    input  free_list_packet_t [N-1:0]    retire_packet,
    input  logic [FL_CTR_W-1:0]          fl_counter,
    output free_list_packet_t [N-1:0]    push_packet,
    output logic                         retire_ready,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         overflow
);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int W     = CNT_W + 1;
    localparam int AW    = (FL_CTR_W + 1 > W) ? FL_CTR_W + 1 : W;
    localparam logic [W-1:0]  DEPTH_W   = W'(DEPTH);
    localparam logic [W-1:0]  N_W       = W'(N);
    localparam logic [AW-1:0] FL_SIZE_A = AW'(FL_SIZE);

    // Handshake: retire_ready high means every lane presented at the next edge is accepted;
    // push_packet has no ready of its own, downstream room is conveyed through fl_counter.

    logic [PRN_W-1:0] fifo_q [DEPTH];
    logic [IDX_W-1:0] head_q;
    logic [IDX_W-1:0] tail_q;
    logic [CNT_W-1:0] count_q;
    logic             overflow_q;

    // base + off modulo DEPTH; off never exceeds DEPTH so one correction suffices
    function automatic logic [IDX_W-1:0] wrap_add(input logic [IDX_W-1:0] base,
                                                  input logic [W-1:0]     off);
        logic [W:0] s;
        s = (W+1)'(base) + {1'b0, off};
        if (s >= {1'b0, DEPTH_W}) s = s - {1'b0, DEPTH_W};
        return s[IDX_W-1:0];
    endfunction

    logic [W-1:0]     free_w;
    logic [W-1:0]     acc_n;
    logic [W-1:0]     k_n;
    logic [N-1:0]     wr_en;
    logic [IDX_W-1:0] wr_idx [N];
    logic             drop;
    logic [AW-1:0]    fl_space;
    logic [AW-1:0]    lim;

    assign free_w = DEPTH_W - W'(count_q);

    // Valid lanes claim slots in ascending order, so the highest lanes are the ones dropped
    always_comb begin
        acc_n = '0;
        wr_en = '0;
        drop  = 1'b0;
        for (int i = 0; i < N; i++) begin
            wr_idx[i] = '0;
            if (retire_packet[i].valid) begin
                if (acc_n < free_w) begin
                    wr_en[i]  = 1'b1;
                    wr_idx[i] = wrap_add(tail_q, acc_n);
                    acc_n     = acc_n + W'(1);
                end else begin
                    drop = 1'b1;
                end
            end
        end
    end

    always_comb begin
        fl_space = (AW'(fl_counter) >= FL_SIZE_A) ? '0 : FL_SIZE_A - AW'(fl_counter);
        lim      = (W'(count_q) < N_W) ? AW'(count_q) : AW'(N_W);
        k_n      = (fl_space < lim) ? W'(fl_space) : W'(lim);
    end

    always_comb begin
        for (int i = 0; i < N; i++) begin
            push_packet[i] = '0;
            if (W'(i) < k_n) begin
                push_packet[i].valid = 1'b1;
                push_packet[i].prn   = fifo_q[wrap_add(head_q, W'(i))];
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            head_q     <= wrap_add(head_q, k_n);
            tail_q     <= wrap_add(tail_q, acc_n);
            count_q    <= CNT_W'(W'(count_q) + acc_n - k_n);
            overflow_q <= overflow_q | drop;
        end
    end

    // Storage needs no reset: head/tail/count decide which slots are meaningful
    always_ff @(posedge clock) begin
        for (int i = 0; i < N; i++) begin
            if (wr_en[i]) fifo_q[wr_idx[i]] <= retire_packet[i].prn;
        end
    end

    assign retire_ready = (free_w >= N_W);
    assign count        = count_q;
    assign overflow     = overflow_q;

endmodule

// File: tb/tb_prn_release_buffer.sv
// Bench for prn_release_buffer: queue-based reference model, randomized and directed traffic.
module tb_prn_release_buffer;
    import prn_release_pkg::*;

    localparam int DEPTH   = 16;
    localparam int FL_SIZE = PHYS_REG_SZ;

    logic                        clock;
    logic                        reset;
    free_list_packet_t [N-1:0]   retire_packet;
    free_list_packet_t [N-1:0]   push_packet;
    logic [FL_CTR_W-1:0]         fl_counter;
    logic                        retire_ready;
    logic [$clog2(DEPTH+1)-1:0]  count;
    logic                        overflow;

    int checks;
    int errors;

    logic [PRN_W-1:0] model_q [$];
    logic [PRN_W-1:0] exp_q [$];
    int               exp_k_q [$];
    int               exp_cnt_q [$];
    int               exp_ovf_q [$];
    bit               model_ovf;

    prn_release_buffer #(.DEPTH(DEPTH), .FL_SIZE(FL_SIZE)) dut (
        .clock         (clock),
        .reset         (reset),
        .retire_packet (retire_packet),
        .fl_counter    (fl_counter),
        .push_packet   (push_packet),
        .retire_ready  (retire_ready),
        .count         (count),
        .overflow      (overflow)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One cycle of stimulus; the model decides this cycle's drain, then this edge's accepts
    task automatic drive(input logic [N-1:0] vld, input int p0, input int p1, input int flc);
        int space;
        int k;
        int free_slots;
        int prns [N];
        @(negedge clock);
        prns[0] = p0;
        prns[1] = p1;
        for (int i = 0; i < N; i++) retire_packet[i] = {vld[i], PRN_W'(prns[i])};
        fl_counter = FL_CTR_W'(flc);
        space = FL_SIZE - flc;
        if (space < 0) space = 0;
        k = model_q.size();
        if (k > N) k = N;
        if (k > space) k = space;
        exp_cnt_q.push_back(model_q.size());
        exp_ovf_q.push_back(int'(model_ovf));
        exp_k_q.push_back(k);
        free_slots = DEPTH - model_q.size();
        repeat (k) exp_q.push_back(model_q.pop_front());
        for (int i = 0; i < N; i++) begin
            if (vld[i]) begin
                if (free_slots > 0) begin
                    model_q.push_back(PRN_W'(prns[i]));
                    free_slots--;
                end else begin
                    model_ovf = 1'b1;
                end
            end
        end
    endtask

    task automatic drain_all();
        for (int i = 0; i < DEPTH + 4 && model_q.size() > 0; i++) drive(2'b00, 0, 0, 0);
        drive(2'b00, 0, 0, 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_count"}, int'(count), 0);
        chk({tag, "_ready"}, int'(retire_ready), 1);
        chk({tag, "_overflow"}, int'(overflow), 0);
        chk({tag, "_push"}, int'(push_packet), 0);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset         = 1'b0;
        retire_packet = '0;
        fl_counter    = '0;
        model_q.delete();
        exp_q.delete();
        model_ovf = 1'b0;
        #1;
        reset_checks("async_reset");
        @(negedge clock);
        #1;
        reset_checks("reset_after");
        reset = 1'b1;
    endtask

    // Monitor: compares whatever the DUT presents against the scoreboard each cycle
    always begin : monitor
        int ek;
        int ecnt;
        int eovf;
        @(negedge clock);
        #2;
        if (exp_k_q.size() > 0) begin
            ek   = exp_k_q.pop_front();
            ecnt = exp_cnt_q.pop_front();
            eovf = exp_ovf_q.pop_front();
            for (int i = 0; i < N; i++) begin
                chk("push_lane_valid", int'(push_packet[i].valid), int'(i < ek));
                if (push_packet[i].valid) begin
                    if (exp_q.size() == 0) chk("push_unexpected", 1, 0);
                    else chk("push_prn", int'(push_packet[i].prn), int'(exp_q.pop_front()));
                end else begin
                    chk("idle_lane_prn", int'(push_packet[i].prn), 0);
                end
            end
            chk("count", int'(count), ecnt);
            chk("retire_ready", int'(retire_ready), int'(DEPTH - ecnt >= N));
            chk("overflow", int'(overflow), eovf);
        end
    end

    initial begin
        checks        = 0;
        errors        = 0;
        reset         = 1'b0;
        retire_packet = '0;
        fl_counter    = '0;
        model_ovf     = 1'b0;
        repeat (2) @(negedge clock);
        #1;
        reset_checks("por");
        reset = 1'b1;

        // Sparse lanes then a full pair: 41 first, then 43,44
        drive(2'b10, 40, 41, 0);
        drive(2'b11, 43, 44, 0);
        drive(2'b00, 0, 0, 0);
        drive(2'b00, 0, 0, 0);

        // Randomized traffic honouring retire_ready, with heavy free-list backpressure
        for (int c = 0; c < 400; c++) begin
            logic [N-1:0] v;
            int flc;
            v = (model_q.size() <= DEPTH - N) ? N'($urandom_range(0, 3)) : '0;
            case ($urandom_range(0, 4))
                0:       flc = 0;
                1:       flc = FL_SIZE - 1;
                2:       flc = FL_SIZE;
                3:       flc = FL_SIZE + int'($urandom_range(1, 3));
                default: flc = int'($urandom_range(FL_SIZE - 4, FL_SIZE));
            endcase
            drive(v, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), flc);
        end
        drain_all();

        // Steady state: two in, two out
        for (int c = 0; c < 100; c++)
            drive(2'b11, int'($urandom_range(0, 63)), int'($urandom_range(0, 63)), 0);
        drain_all();

        // Mid-stream reset with five entries held
        drive(2'b11, 1, 2, FL_SIZE);
        drive(2'b11, 3, 4, FL_SIZE);
        drive(2'b01, 5, 0, FL_SIZE);
        @(negedge clock);
        #3;
        chk("pre_reset_count", int'(count), 5);
        do_reset();

        // Walk head/tail to slot 15, then straddle the wrap
        for (int i = 0; i < 15; i++) drive(2'b01, 10 + i, 0, 0);
        drive(2'b11, 50, 51, 0);
        drive(2'b00, 0, 0, 0);
        drive(2'b00, 0, 0, 0);

        // Fill with the free list full, then overrun by one lane
        for (int i = 0; i < DEPTH / N; i++) drive(2'b11, 20 + 2 * i, 21 + 2 * i, FL_SIZE);
        drive(2'b01, 33, 0, FL_SIZE);
        for (int i = 0; i < 4; i++) drive(2'b00, 0, 0, FL_SIZE - 1);
        drain_all();
        drive(2'b00, 0, 0, 0);

        @(negedge clock);
        #3;
        chk("scoreboard_empty", exp_q.size(), 0);
        chk("overflow_sticky", int'(overflow), 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
